// File: rtl/clock_div_gen_pkg.sv
// clock_div_gen_pkg
//   Shared constants and helpers for the clock_div_gen divider.
//   SYS_CLK_HZ          : nominal system clock frequency.
//   DEFAULT_HALF_PERIOD : half-period that yields 1 Hz from SYS_CLK_HZ.
//   half_period()       : sys_hz / (2 * out_hz), never less than 1.
package clock_div_gen_pkg;

    localparam int unsigned SYS_CLK_HZ = 50_000_000;

    function automatic int unsigned half_period(input int unsigned sys_hz,
                                                input int unsigned out_hz);
        int unsigned q;
        // A 0 Hz request has no meaningful divider; clamp to the fastest one.
        if (out_hz == 0) begin
            q = 1;
        end else begin
            q = sys_hz / (2 * out_hz);
        end
        if (q == 0) begin
            q = 1;
        end
        return q;
    endfunction

    localparam int unsigned DEFAULT_HALF_PERIOD = half_period(SYS_CLK_HZ, 1);

endpackage

// File: rtl/div_mod_counter.sv
// div_mod_counter
//   Enable-gated modulo counter: counts 0..last while en=1 and wraps to 0.
//   Ports:
//     clk_in : clock, rising edge
//     rst    : synchronous active-high reset (count -> 0), priority over en
//     en     : count enable; low holds the count
//     last   : terminal count value (modulus - 1)
//     wrap   : high in the cycle whose edge takes the count from last to 0
module div_mod_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] last,
    output logic             wrap
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        wrap    = en && (count_q == last);
        count_d = count_q;
        if (wrap) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/clock_div_gen.sv
// clock_div_gen
//   Integer clock divider producing a registered 50% duty square wave and a
//   one-cycle tick aligned with each rising edge of that wave.
//   Optional macro CLOCK_DIV_GEN_RUNTIME_DIV_EN adds a run-time reloadable
//   half-period (div_load / div_value), applied glitch-free at the next wrap.
//   Ports:
//     clk_in    : system clock, rising edge
//     rst       : synchronous active-high reset, priority over en
//     en        : count enable; low freezes counter, clk_out and tick
//     div_load  : (macro only) capture div_value into the shadow half-period
//     div_value : (macro only) new half-period in clk_in cycles; 0 acts as 1
//     clk_out   : divided clock, driven from a flop
//     tick      : one-cycle strobe with each 0->1 transition of clk_out
module clock_div_gen
    import clock_div_gen_pkg::*;
#(
    parameter  int unsigned HALF_PERIOD = DEFAULT_HALF_PERIOD,
    localparam int unsigned CNT_W       = $clog2(HALF_PERIOD + 1)
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
`ifdef CLOCK_DIV_GEN_RUNTIME_DIV_EN
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_value,
`endif
    output logic             clk_out,
    output logic             tick
);

    if (HALF_PERIOD < 1) begin : g_bad_half_period
        $error("clock_div_gen: HALF_PERIOD must be >= 1");
    end

    logic             wrap;
    logic [CNT_W-1:0] last;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;

`ifdef CLOCK_DIV_GEN_RUNTIME_DIV_EN
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;

    // A pending value is promoted only on a wrap, so the half-period in
    // progress always completes at its old length. A load landing on the
    // wrap edge itself stays pending until the following wrap.
    always_comb begin
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (wrap && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (div_load) begin
            shadow_d  = (div_value == '0) ? CNT_W'(1) : div_value;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            active_q  <= CNT_W'(HALF_PERIOD);
            shadow_q  <= CNT_W'(HALF_PERIOD);
            pending_q <= 1'b0;
        end else begin
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
        end
    end

    // active_q is never 0, so this cannot underflow.
    assign last = active_q - CNT_W'(1);
`else
    assign last = CNT_W'(HALF_PERIOD - 1);
`endif

    div_mod_counter #(
        .WIDTH (CNT_W)
    ) u_counter (
        .clk_in (clk_in),
        .rst    (rst),
        .en     (en),
        .last   (last),
        .wrap   (wrap)
    );

    always_comb begin
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;
        if (wrap) begin
            clk_out_d = ~clk_out_q;
            // Only the 0->1 toggle produces a tick.
            tick_d    = ~clk_out_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_clock_div_gen.sv
module tb_clock_div_gen;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic rst = 1'b1;
    logic en  = 1'b0;
    logic c4, t4, c1, t1, c3, t3;

    int     vectors     = 0;
    int     miscompares = 0;
    longint n           = 0;  // enabled edges since the last reset edge

`ifdef CLOCK_DIV_GEN_RUNTIME_DIV_EN
    logic       div_load  = 1'b0;
    logic [2:0] div_value = '0;
`endif

    clock_div_gen #(.HALF_PERIOD(4)) dut4 (
        .clk_in    (clk_in),
        .rst       (rst),
        .en        (en),
`ifdef CLOCK_DIV_GEN_RUNTIME_DIV_EN
        .div_load  (div_load),
        .div_value (div_value),
`endif
        .clk_out   (c4),
        .tick      (t4)
    );

    clock_div_gen #(.HALF_PERIOD(1)) dut1 (
        .clk_in    (clk_in),
        .rst       (rst),
        .en        (en),
`ifdef CLOCK_DIV_GEN_RUNTIME_DIV_EN
        .div_load  (1'b0),
        .div_value ('0),
`endif
        .clk_out   (c1),
        .tick      (t1)
    );

    clock_div_gen #(.HALF_PERIOD(3)) dut3 (
        .clk_in    (clk_in),
        .rst       (rst),
        .en        (en),
`ifdef CLOCK_DIV_GEN_RUNTIME_DIV_EN
        .div_load  (1'b0),
        .div_value ('0),
`endif
        .clk_out   (c3),
        .tick      (t3)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: after n enabled edges, clk_out has toggled floor(n/H) times.
    function automatic logic exp_clk(input longint h);
        return ((n / h) % 2) == 1;
    endfunction

    // A tick follows an enabled edge that completed an odd number of half-periods.
    function automatic logic exp_tick(input longint h, input logic r, input logic e);
        return !r && e && (n > 0) && ((n % h) == 0) && (((n / h) % 2) == 1);
    endfunction

    task automatic step(input logic r, input logic e);
        rst = r;
        en  = e;
        @(posedge clk_in);
        #1;
        if (r) n = 0;
        else if (e) n++;
        check("clk_out_h4", c4, exp_clk(4));
        check("tick_h4",    t4, exp_tick(4, r, e));
        check("clk_out_h1", c1, exp_clk(1));
        check("tick_h1",    t1, exp_tick(1, r, e));
        check("clk_out_h3", c3, exp_clk(3));
        check("tick_h3",    t3, exp_tick(3, r, e));
    endtask

`ifdef CLOCK_DIV_GEN_RUNTIME_DIV_EN
    // Hand-derived: half-period 4, then 2 from the wrap at edge 4 (load at
    // edge 2), then 1 from the wrap at edge 16 (load of 0 on wrap edge 14).
    logic exp_rc [20] = '{0,0,0,1,1,0,0,1,1,0,0,1,1,0,0,1,0,1,0,1};
    logic exp_rt [20] = '{0,0,0,1,0,0,0,1,0,0,0,1,0,0,0,1,0,1,0,1};
`endif

    initial begin
        // Reset state, with and without en.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        repeat (10) step(1'b1, 1'b1);

        // Free run from reset release.
        repeat (16) step(1'b0, 1'b1);

        // en dropped for 3 cycles at count 2.
        step(1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b1);

        // One-cycle reset while clk_out=1 at count 3 (n=7 for H=4).
        step(1'b1, 1'b1);
        repeat (7) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (10) step(1'b0, 1'b1);

        // Randomised enable and occasional reset.
        repeat (400) begin
            step($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0);
        end

`ifdef CLOCK_DIV_GEN_RUNTIME_DIV_EN
        rst = 1'b1;
        en  = 1'b1;
        @(posedge clk_in);
        #1;
        check("rt_reset_clk", c4, 1'b0);
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            div_load  = (k == 2) || (k == 14);
            div_value = (k == 2) ? 3'd2 : 3'd0;
            @(posedge clk_in);
            #1;
            div_load = 1'b0;
            check($sformatf("rt_clk_e%0d", k), c4, exp_rc[k-1]);
            check($sformatf("rt_tick_e%0d", k), t4, exp_rt[k-1]);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
